// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: command encodings, FSM states,
// decode targets and default peripheral addresses.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10,
        MRSVD  = 2'b11
    } mem_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_LED  = 2'd1,
        TGT_SW   = 2'd2,
        TGT_NONE = 2'd3
    } tgt_t;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/mem_responder_if.sv
// Initiator <-> responder memory bus: command, address, data and ready pulse.
interface mem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;

    modport master (
        output mem_cmd, mem_addr, write_data,
        input  read_data, mem_ready
    );

    modport slave (
        input  mem_cmd, mem_addr, write_data,
        output read_data, mem_ready
    );
endinterface

// File: rtl/mem_responder_ram_sp.sv
// Single-port RAM with synchronous write and registered read; contents are
// deliberately not reset.
module ram_sp #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-mapped responder: RAM, an LED register and a synchronized switch port
// behind a command/ready bus, with a sticky error flag for bad accesses.
//
// state   | meaning
// ST_IDLE | sample command; writes and RAM read-fetch happen on this edge
// ST_RD   | load read_data from the latched target, pulse mem_ready
// ST_WR   | write already done, pulse mem_ready
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int               ADDR_W    = 9,
    parameter int               DATA_W    = 16,
    parameter int               RAM_DEPTH = 256,
    parameter logic [ADDR_W-1:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR  = SW_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_responder_if.slave       bus,
    input  logic [9:0]           sw,
    output logic [7:0]           led,
    output logic                 err
);
    localparam int RAM_AW = $clog2(RAM_DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              mem_ready_q, mem_ready_d;
    logic [7:0]        led_q, led_d;
    logic              err_q, err_d;
    logic [9:0]        sw_meta_q, sw_sync_q;

    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    tgt_t              cmd_tgt, addr_tgt;

    function automatic tgt_t decode(input logic [ADDR_W-1:0] a);
        if (a < ADDR_W'(RAM_DEPTH)) return TGT_RAM;
        else if (a == LED_ADDR)     return TGT_LED;
        else if (a == SW_ADDR)      return TGT_SW;
        else                        return TGT_NONE;
    endfunction

    ram_sp #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.mem_addr[RAM_AW-1:0]),
        .wdata (bus.write_data),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        read_data_d = read_data_q;
        mem_ready_d = 1'b0;
        led_d       = led_q;
        err_d       = err_q;
        ram_we      = 1'b0;
        cmd_tgt     = decode(bus.mem_addr);
        addr_tgt    = decode(addr_q);

        case (state_q)
            ST_IDLE: begin
                case (bus.mem_cmd)
                    MREAD: begin
                        addr_d  = bus.mem_addr;
                        state_d = ST_RD;
                        if (cmd_tgt == TGT_NONE) err_d = 1'b1;
                    end
                    MWRITE: begin
                        state_d = ST_WR;
                        case (cmd_tgt)
                            TGT_RAM:  ram_we = 1'b1;
                            TGT_LED:  led_d  = bus.write_data[7:0];
                            TGT_SW:   ;
                            default:  err_d  = 1'b1;
                        endcase
                    end
                    MRSVD:   err_d = 1'b1;
                    default: ;
                endcase
            end
            ST_RD: begin
                mem_ready_d = 1'b1;
                state_d     = ST_IDLE;
                read_data_d = '0;
                case (addr_tgt)
                    TGT_RAM: read_data_d      = ram_rdata;
                    TGT_LED: read_data_d[7:0] = led_q;
                    TGT_SW:  read_data_d[9:0] = sw_sync_q;
                    default: ;
                endcase
            end
            ST_WR: begin
                mem_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            read_data_q <= '0;
            mem_ready_q <= 1'b0;
            led_q       <= '0;
            err_q       <= 1'b0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            read_data_q <= read_data_d;
            mem_ready_q <= mem_ready_d;
            led_q       <= led_d;
            err_q       <= err_d;
            sw_meta_q   <= sw;
            sw_sync_q   <= sw_meta_q;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.mem_ready = mem_ready_q;
    assign led           = led_q;
    assign err           = err_q;
endmodule
